// File: rtl/if_id_stage.sv
// IF/ID pipeline register: latches the fetched instruction and PC+PC_INC, and drives the PC write enable.
// Defining IF_ID_FETCH_COUNT_EN adds a fetch_count output that the debug unit reads.
module if_id_stage #(
    parameter logic [31:0] PC_INC      = 32'd1,
    parameter logic [31:0] RESET_PC    = 32'hFFFF_FFFF,
    parameter logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_next_out,
    output logic        valid_out,
    output logic        halted,
    output logic        pc_write
`ifdef IF_ID_FETCH_COUNT_EN
   ,output logic [31:0] fetch_count
`endif
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t state;
    logic   bubble;
    logic   halt_fetch;
    logic   load;

    assign bubble     = (pc_in == RESET_PC);
    assign halt_fetch = (state == ST_RUN) && !bubble && (instr_in == HALT_OPCODE);
    assign load       = en && !flush && (state == ST_RUN) && !stall;
    assign halted     = (state == ST_HALTED);

    // Not gated by en: the PC register applies the debug enable itself.
    assign pc_write = (state == ST_RUN) && (flush || !stall) && !(halt_fetch && !flush);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_out   <= '0;
            pc_next_out <= '0;
            valid_out   <= 1'b0;
            state       <= ST_RUN;
        end else if (en) begin
            if (flush) begin
                // Also cancels a wrong-path HALT; pc_next_out deliberately holds.
                instr_out <= '0;
                valid_out <= 1'b0;
                state     <= ST_RUN;
            end else if (state == ST_HALTED) begin
                instr_out <= '0;
                valid_out <= 1'b0;
            end else if (!stall) begin
                instr_out   <= bubble ? 32'd0 : instr_in;
                valid_out   <= !bubble;
                pc_next_out <= pc_in + PC_INC;
                if (halt_fetch)
                    state <= ST_HALTED;
            end
        end
    end

`ifdef IF_ID_FETCH_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            fetch_count <= '0;
        else if (load && !bubble)
            fetch_count <= fetch_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: stimulus pushes hand-computed expectations, a monitor pops and compares.
// Covers reset, bubble, load, stall, stall+flush, HALT, flush-from-HALTED, en=0 hold and reset mid-halt.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst, en, stall, flush;
    logic [31:0] pc_in, instr_in;
    logic [31:0] instr_out, pc_next_out;
    logic        valid_out, halted, pc_write;
`ifdef IF_ID_FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string       name;
        logic        chk_pw;
        logic        pw;
        logic [31:0] instr;
        logic [31:0] pnext;
        logic        valid;
        logic        hlt;
        logic [31:0] fc;
    } exp_t;

    exp_t exp_q[$];

    if_id_stage dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .stall      (stall),
        .flush      (flush),
        .pc_in      (pc_in),
        .instr_in   (instr_in),
        .instr_out  (instr_out),
        .pc_next_out(pc_next_out),
        .valid_out  (valid_out),
        .halted     (halted),
        .pc_write   (pc_write)
`ifdef IF_ID_FETCH_COUNT_EN
       ,.fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge and queue the expected response.
    task automatic step(input string name, input logic r, input logic e, input logic s, input logic f,
                        input logic [31:0] pc, input logic [31:0] ins,
                        input logic chk_pw, input logic pw,
                        input logic [31:0] x_instr, input logic [31:0] x_pnext,
                        input logic x_valid, input logic x_hlt, input logic [31:0] x_fc);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; stall = s; flush = f; pc_in = pc; instr_in = ins;
        x.name = name; x.chk_pw = chk_pw; x.pw = pw; x.instr = x_instr; x.pnext = x_pnext;
        x.valid = x_valid; x.hlt = x_hlt; x.fc = x_fc;
        exp_q.push_back(x);
    endtask

    // Monitor: pc_write is checked mid-low-phase against current inputs, registers #1 after the edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                if (x.chk_pw)
                    check({x.name, ".pc_write"}, {31'd0, pc_write}, {31'd0, x.pw});
                @(posedge clk);
                #1;
                check({x.name, ".instr_out"},   instr_out,   x.instr);
                check({x.name, ".pc_next_out"}, pc_next_out, x.pnext);
                check({x.name, ".valid_out"},   {31'd0, valid_out}, {31'd0, x.valid});
                check({x.name, ".halted"},      {31'd0, halted},    {31'd0, x.hlt});
`ifdef IF_ID_FETCH_COUNT_EN
                check({x.name, ".fetch_count"}, fetch_count, x.fc);
`endif
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b0; en = 1'b0; stall = 1'b0; flush = 1'b0; pc_in = '0; instr_in = '0;

        //      name         rst en st fl  pc_in         instr_in     chk pw  instr_out     pnext     v  h  fc
        step("reset0",       0, 1, 0, 0, 32'd0,        32'h0,        0, 0, 32'h0,        32'd0,    0, 0, 0);
        step("reset1",       0, 1, 0, 0, 32'd0,        32'h0,        1, 1, 32'h0,        32'd0,    0, 0, 0);
        step("bubble",       1, 1, 0, 0, 32'hFFFFFFFF, 32'h12345678, 1, 1, 32'h0,        32'd0,    0, 0, 0);
        step("load_pc5",     1, 1, 0, 0, 32'd5,        32'h8C220004, 1, 1, 32'h8C220004, 32'd6,    1, 0, 1);
        step("load_pc7",     1, 1, 0, 0, 32'd7,        32'hAABBCCDD, 1, 1, 32'hAABBCCDD, 32'd8,    1, 0, 2);
        step("stall_a",      1, 1, 1, 0, 32'd8,        32'h11111111, 1, 0, 32'hAABBCCDD, 32'd8,    1, 0, 2);
        step("stall_b",      1, 1, 1, 0, 32'd9,        32'h22222222, 1, 0, 32'hAABBCCDD, 32'd8,    1, 0, 2);
        step("stall_flush",  1, 1, 1, 1, 32'd20,       32'h33333333, 1, 1, 32'h0,        32'd8,    0, 0, 2);
        step("halt_fetch",   1, 1, 0, 0, 32'd9,        32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 32'd10,   1, 1, 3);
        for (int i = 0; i < 10; i++)
            step($sformatf("halted_%0d", i),
                             1, 1, i[0], 0, 32'd9,     32'hFFFFFFFF, 1, 0, 32'h0,        32'd10,   0, 1, 3);
        step("flush_halt",   1, 1, 0, 1, 32'd40,       32'h0,        1, 0, 32'h0,        32'd10,   0, 0, 3);
        step("resume",       1, 1, 0, 0, 32'd40,       32'h01234567, 1, 1, 32'h01234567, 32'd41,   1, 0, 4);
        step("en0_flush_a",  1, 0, 0, 1, 32'd50,       32'h55,       1, 1, 32'h01234567, 32'd41,   1, 0, 4);
        step("en0_flush_b",  1, 0, 1, 1, 32'd60,       32'h66,       1, 1, 32'h01234567, 32'd41,   1, 0, 4);
        step("en0_stall",    1, 0, 1, 0, 32'd61,       32'h67,       1, 0, 32'h01234567, 32'd41,   1, 0, 4);
        step("reset_mid",    0, 1, 0, 0, 32'd70,       32'h77,       1, 1, 32'h0,        32'd0,    0, 0, 0);
        step("halt_again",   1, 1, 0, 0, 32'd80,       32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 32'd81,   1, 1, 1);
        step("reset_halt",   0, 1, 0, 0, 32'd80,       32'hFFFFFFFF, 1, 0, 32'h0,        32'd0,    0, 0, 0);
        step("after_reset",  1, 1, 0, 0, 32'd90,       32'h0000000A, 1, 1, 32'h0000000A, 32'd91,   1, 0, 1);
        step("flush_cancel", 1, 1, 0, 1, 32'd95,       32'hFFFFFFFF, 1, 1, 32'h0,        32'd91,   0, 0, 1);

        budget = 0;
        while (exp_q.size() > 0 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
